instr_feeder: RTL and testbench
===============================

# instr_feeder

Synthesizable initiator for the processor's `run`/`din`/`done` instruction interface, the RTL counterpart of the bench-side driver. It holds a small loadable program memory, issues each instruction to `cpu` with a one-cycle `run` pulse, and presents the immediate word for `mvi`. It waits for `done` between instructions and records the last `dout` value and the instruction count. It sits between a host/loader and `cpu`, so a program runs with no testbench stimulus.

## Interface
- `DATA_W`, 16: instruction/data word width.
- `DEPTH`, 32: program memory words; `AW = $clog2(DEPTH)`.
- `TIMEOUT`, 64: maximum WAIT cycles without `done` before the block flags an error.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in 1: single clock, rising edge.
  - `resetn` in 1: asynchronous, active-low reset.
- Loader and control:
  - `wr_en` in 1: program write strobe.
  - `wr_addr` in AW: write address.
  - `wr_data` in DATA_W: write data.
  - `start` in 1: begin program at address 0.
  - `prog_len` in AW+1: number of words to execute; latched at start and clamped to DEPTH.
- Processor side:
  - `done` in 1: processor instruction-complete pulse.
  - `dout` in DATA_W: processor result bus.
  - `run` out 1: instruction-valid pulse to processor.
  - `din` out DATA_W: instruction/immediate word to processor.
- Status:
  - `busy` out 1: high in ISSUE and WAIT.
  - `finished` out 1: one-cycle pulse when the program completes.
  - `error` out 1: sticky; set on timeout or protocol violation.
  - `last_dout` out DATA_W: `dout` captured at the most recent `done`.
  - `instr_count` out 16: instructions completed since `start`, saturating at 0xFFFF.

## Operation
- Instruction word fields: `op = din[15:13]`, `rx = [12:10]`, `ry = [9:7]`. Opcodes: mv = 000, mvi = 001, add = 010, sub = 011. Only `mvi` takes an immediate (the next word).
- Program memory:
  - Asynchronous read.
  - Write on `wr_en` only while not busy; writes are ignored in ISSUE and WAIT.
  - Memory contents are not reset.
- States:
  - IDLE: `run = 0`, `din = 0`.
    - `start` with latched length 0 → FINISH.
    - Any other `start` → ISSUE, with `pc = 0`, `instr_count = 0`, `error` cleared.
  - ISSUE (exactly one cycle): `run = 1`, `din = mem[pc]`. At exit: `pc <= pc+1`, `has_imm <= (op == mvi)`, timer cleared → WAIT.
  - WAIT: `run = 0`; `din = has_imm ? mem[pc] : 0`; the timer increments each cycle.
    - On `done`: `last_dout <= dout`, `instr_count++`, `pc <= pc + has_imm`. Then, if the new `pc >= len` → FINISH, else → ISSUE.
    - If the timer reaches TIMEOUT−1 without `done` → ERROR.
  - FINISH (one cycle): `finished = 1` → IDLE.
  - ERROR: `error = 1`, `run = 0`, `din = 0`. Held until `start`, which behaves as in IDLE.
- Boundary cases:
  - `done` during ISSUE is a protocol violation → ERROR.
  - `done` in IDLE, FINISH or ERROR is ignored.
  - An `mvi` at the last address reads its immediate from `mem[pc]`, with the address wrapping modulo DEPTH. The program then finishes after that `done`.
  - `start` while busy is ignored.
  - `start` in the FINISH cycle is ignored.
  - `wr_en` coinciding with `start` in IDLE: the write takes effect, and the first ISSUE, one cycle later, sees the new data.
  - Reset mid-program: immediate return to IDLE; all outputs go to their reset values.

## Timing
- Reset values: `run = 0`, `din = 0`, `busy = 0`, `finished = 0`, `error = 0`, `last_dout = 0`, `instr_count = 0`; internal `pc = 0`, `state = IDLE`.
- `start` sampled at edge N → `run = 1` during cycle N+1.
- `done` sampled in WAIT at edge M → the next `run` is in cycle M+1, or `finished` is in cycle M+1.
- Minimum spacing between `run` pulses is 2 cycles.
- `din` is stable for the whole WAIT state.
- All outputs are registered state decodes; there are no combinational paths from `done`/`dout` to `run`/`din`.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants;
  - `OP_MSB`/`OP_LSB` field positions;
  - `feeder_state_t` enum (IDLE, ISSUE, WAIT, FINISH, ERROR).
- Sub-module `prog_mem`: DEPTH×DATA_W, one write port and one asynchronous read port. The FSM, pc, timer and status registers stay in `instr_feeder`.

## Test plan
- Reset: hold `resetn = 0` → `run = 0`, `din = 0x0000`, `busy = 0`, `error = 0`, `instr_count = 0`.
- Single mv: `mem[0] = 0x0400`, `prog_len = 1`, processor model returns `done` with `dout = 0x0007` 3 cycles after `run` → exactly one `run` pulse with `din = 0x0400`; `finished` one cycle after `done`; `last_dout = 0x0007`; `instr_count = 1`.
- mvi + add: `mem = {0x2000, 0x0005, 0x4080}`, `prog_len = 3` → two `run` pulses with `din` 0x2000 then 0x4080; `din = 0x0005` throughout the first WAIT; `instr_count = 2`.
- Timeout: `TIMEOUT = 64`, `done` never asserted → `error = 1` after 64 WAIT cycles; `run` stays 0; next `start` clears `error` and reissues `mem[0]`.
- Empty program: `prog_len = 0`, `start` → `finished` next cycle; no `run` pulse.
- Interference: `wr_en` to `mem[0]` and a second `start` during WAIT → both ignored. `done` asserted during ISSUE → `error = 1`. `resetn` low mid-WAIT → IDLE with all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the instruction feeder and its program memory.
// Holds the instruction opcode constants, the position of the opcode field
// inside an instruction word, and the feeder state encoding.
package cpu_pkg;

  // Opcode field position inside an instruction word
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;

  // Opcodes understood by the processor; only mvi is followed by an immediate
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Feeder sequencing states
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH,
    ERROR
  } feeder_state_t;

endpackage

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x DATA_W program store for the instruction feeder.
// One synchronous write port and one asynchronous read port. Contents are not
// reset, so a program survives a reset of the feeder.
// Ports:
//   clock    - write clock, rising edge
//   wr_en    - write strobe (already qualified by the feeder)
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - word at rd_addr, combinational
module prog_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: runs a program held in a local memory against the processor's
// run/din/done interface without any outside stimulus.
// Each instruction is issued with a one-cycle run pulse; the immediate word of
// an mvi is presented on din for the whole wait that follows. The feeder waits
// for done between instructions, records the last dout and counts completed
// instructions. A missing done (timeout) or a done during the issue cycle
// parks the feeder in ERROR until the next start.
// Ports:
//   clock, resetn         - clock (rising edge) and async active-low reset
//   wr_en/wr_addr/wr_data - program loader, ignored while busy
//   start, prog_len       - launch a program of prog_len words from address 0
//   done, dout            - processor completion pulse and result bus
//   run, din              - instruction-valid pulse and instruction/immediate
//   busy                  - high while issuing or waiting
//   finished              - one-cycle pulse at program completion
//   error                 - high while parked after a timeout/protocol error
//   last_dout             - dout captured at the most recent done
//   instr_count           - instructions completed since start, saturating
module instr_feeder
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [AW:0]       prog_len,
  input  logic              done,
  input  logic [DATA_W-1:0] dout,
  output logic              run,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [DATA_W-1:0] last_dout,
  output logic [15:0]       instr_count
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_LEN  = (AW+1)'(DEPTH);

  feeder_state_t     state, next_state;
  logic [AW:0]       pc;
  logic [AW:0]       len;
  logic [AW:0]       start_len;
  logic [AW:0]       pc_after_done;
  logic              has_imm;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] mem_word;

  assign start_len     = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign pc_after_done = pc + {{AW{1'b0}}, has_imm};

  // pc can run one or two past the last address; the low bits wrap so an mvi
  // in the final slot fetches its immediate from address 0.
  prog_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clock  (clock),
    .wr_en  (wr_en && !busy),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(pc[AW-1:0]),
    .rd_data(mem_word)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; ERROR accepts start exactly like IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE, ERROR: begin
        if (start) begin
          next_state = (start_len == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        next_state = done ? ERROR : WAIT;
      end
      WAIT: begin
        if (done) begin
          next_state = (pc_after_done >= len) ? FINISH : ISSUE;
        end else if (timer == TIMER_LAST) begin
          next_state = ERROR;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Program counter, immediate flag, wait timer and status registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc          <= '0;
      len         <= '0;
      has_imm     <= 1'b0;
      timer       <= '0;
      last_dout   <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            len <= start_len;
            if (start_len != '0) begin
              pc          <= '0;
              instr_count <= '0;
            end
          end
        end
        ISSUE: begin
          pc      <= pc + 1'b1;
          has_imm <= (mem_word[OP_MSB:OP_LSB] == OP_MVI);
          timer   <= '0;
        end
        WAIT: begin
          if (done) begin
            last_dout <= dout;
            pc        <= pc_after_done;
            if (instr_count != 16'hFFFF) begin
              instr_count <= instr_count + 16'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from the registered state only; done/dout never reach run/din
  always_comb begin
    run      = 1'b0;
    din      = '0;
    busy     = 1'b0;
    finished = 1'b0;
    error    = 1'b0;
    case (state)
      ISSUE: begin
        run  = 1'b1;
        din  = mem_word;
        busy = 1'b1;
      end
      WAIT: begin
        busy = 1'b1;
        din  = has_imm ? mem_word : '0;
      end
      FINISH: begin
        finished = 1'b1;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: self-checking bench for instr_feeder.
// A processor model answers each run pulse with done after a chosen latency.
// Expected issue order, immediates, counts and last result come from walking a
// shadow copy of the program memory with the instruction-set rules.
`timescale 1ns/1ps
module tb_instr_feeder;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 64;
  localparam int AW      = 5;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [AW:0]       prog_len = '0;
  logic              done = 1'b0;
  logic [DATA_W-1:0] dout = '0;
  logic              run;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              finished;
  logic              error;
  logic [DATA_W-1:0] last_dout;
  logic [15:0]       instr_count;

  int assert_count = 0;
  int fail_count = 0;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_last = '0;
  int          model_count = 0;

  always #5 clock = ~clock;

  instr_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .prog_len   (prog_len),
    .done       (done),
    .dout       (dout),
    .run        (run),
    .din        (din),
    .busy       (busy),
    .finished   (finished),
    .error      (error),
    .last_dout  (last_dout),
    .instr_count(instr_count)
  );

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Loader write through the program port, mirrored into the shadow memory
  task automatic writeWord(input int addr, input logic [15:0] data);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = data;
    model_mem[addr] = data;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Launch a program and play the processor until finished.
  // fixed_lat 0 = random latency, fixed_dout < 0 = random result.
  // interfere: write mem[0] and pulse start during the first wait.
  // ws: write mem[0] in the same cycle as start.
  task automatic applyStimulus(input int len, input int fixed_lat, input int fixed_dout,
                               input bit interfere, input bit ws, input logic [15:0] ws_data);
    logic [15:0] exp_word[$];
    logic [15:0] exp_imm[$];
    logic [15:0] d;
    logic [15:0] w;
    int eff, pc, n, idx, countdown, lat, cycles, runs;
    bit in_wait, expect_step, interfered;
    @(negedge clock);
    if (ws) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = ws_data;
      model_mem[0] = ws_data;
    end
    start    = 1'b1;
    prog_len = len[AW:0];
    eff = (len > DEPTH) ? DEPTH : len;
    pc = 0;
    while (pc < eff) begin
      w = model_mem[pc % DEPTH];
      exp_word.push_back(w);
      if (w[15:13] == 3'b001) begin
        exp_imm.push_back(model_mem[(pc + 1) % DEPTH]);
        pc += 2;
      end else begin
        exp_imm.push_back(16'h0000);
        pc += 1;
      end
    end
    n = exp_word.size();
    if (n > 0) model_count = 0;
    idx = 0; countdown = 0; cycles = 0; runs = 0;
    in_wait = 1'b0; expect_step = 1'b1; interfered = 1'b0;
    forever begin
      @(negedge clock);
      start = 1'b0;
      wr_en = 1'b0;
      done  = 1'b0;
      cycles++;
      if (cycles > 2000) begin
        checkOutput("cycle_budget", 32'(0), 32'(1));
        break;
      end
      if (expect_step) begin
        checkOutput("run_next", 32'(run), 32'(idx < n));
        checkOutput("finished_next", 32'(finished), 32'(idx == n));
        checkOutput("error_clear", 32'(error), 32'(0));
        expect_step = 1'b0;
      end
      if (finished) break;
      if (run) begin
        runs++;
        if (idx < n) checkOutput("issue_din", 32'(din), 32'(exp_word[idx]));
        else checkOutput("extra_run", 32'(runs), 32'(n));
        checkOutput("busy_issue", 32'(busy), 32'(1));
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        if (interfere && lat < 2) lat = 2;
        countdown = lat;
        in_wait = 1'b1;
      end else if (in_wait) begin
        checkOutput("wait_din", 32'(din), 32'((idx < n) ? exp_imm[idx] : 16'h0000));
        checkOutput("busy_wait", 32'(busy), 32'(1));
        if (interfere && !interfered) begin
          interfered = 1'b1;
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_data  = ~model_mem[0];
          start    = 1'b1;
          prog_len = 6'd1;
        end
        countdown--;
        if (countdown == 0) begin
          d = (fixed_dout >= 0) ? fixed_dout[15:0] : 16'($urandom);
          done = 1'b1;
          dout = d;
          model_last = d;
          model_count++;
          idx++;
          in_wait = 1'b0;
          expect_step = 1'b1;
        end
      end
    end
    checkOutput("run_pulses", 32'(runs), 32'(n));
    checkOutput("instr_count", 32'(instr_count), 32'(model_count));
    checkOutput("last_dout", 32'(last_dout), 32'(model_last));
    checkOutput("busy_finish", 32'(busy), 32'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] word;
    int cnt;

    // Reset state
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_run", 32'(run), 32'(0));
    checkOutput("rst_din", 32'(din), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_error", 32'(error), 32'(0));
    checkOutput("rst_finished", 32'(finished), 32'(0));
    checkOutput("rst_count", 32'(instr_count), 32'(0));
    checkOutput("rst_last", 32'(last_dout), 32'(0));
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < DEPTH; i++) writeWord(i, 16'h0000);

    // Single mv, done 3 cycles after run with result 7
    writeWord(0, 16'h0400);
    applyStimulus(1, 3, 7, 1'b0, 1'b0, 16'h0000);
    checkOutput("mv_last_dout", 32'(last_dout), 32'(16'h0007));
    checkOutput("mv_count", 32'(instr_count), 32'(1));

    // mvi + add
    writeWord(0, 16'h2000);
    writeWord(1, 16'h0005);
    writeWord(2, 16'h4080);
    applyStimulus(3, 0, -1, 1'b0, 1'b0, 16'h0000);
    checkOutput("mvi_add_count", 32'(instr_count), 32'(2));

    // Empty program
    applyStimulus(0, 0, -1, 1'b0, 1'b0, 16'h0000);

    // Loader write and start during WAIT are ignored
    writeWord(0, 16'h0400);
    writeWord(1, 16'h4080);
    applyStimulus(2, 0, -1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(2, 0, -1, 1'b0, 1'b0, 16'h0000);

    // Write coinciding with start is seen by the first issue
    applyStimulus(2, 0, -1, 1'b0, 1'b1, 16'h6300);

    // Timeout: no done ever
    writeWord(0, 16'h0480);
    @(negedge clock);
    start = 1'b1;
    prog_len = 6'd1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("to_run", 32'(run), 32'(1));
    checkOutput("to_din", 32'(din), 32'(16'h0480));
    cnt = 0;
    while (!error && cnt < 200) begin
      @(negedge clock);
      cnt++;
      checkOutput("to_run_low", 32'(run), 32'(0));
    end
    checkOutput("to_cycles", 32'(cnt), 32'(TIMEOUT + 1));
    checkOutput("to_error", 32'(error), 32'(1));
    checkOutput("to_busy", 32'(busy), 32'(0));
    model_count = 0;
    applyStimulus(1, 0, -1, 1'b0, 1'b0, 16'h0000);

    // done during ISSUE is a protocol violation; done in ERROR is ignored
    @(negedge clock);
    start = 1'b1;
    prog_len = 6'd2;
    @(negedge clock);
    start = 1'b0;
    checkOutput("pv_run", 32'(run), 32'(1));
    done = 1'b1;
    dout = 16'hBEEF;
    @(negedge clock);
    checkOutput("pv_error", 32'(error), 32'(1));
    checkOutput("pv_run_low", 32'(run), 32'(0));
    checkOutput("pv_count", 32'(instr_count), 32'(0));
    checkOutput("pv_last", 32'(last_dout), 32'(model_last));
    @(negedge clock);
    done = 1'b0;
    checkOutput("pv_error_held", 32'(error), 32'(1));
    checkOutput("pv_last_held", 32'(last_dout), 32'(model_last));
    model_count = 0;
    applyStimulus(2, 0, -1, 1'b0, 1'b0, 16'h0000);

    // mvi in the last slot takes its immediate from address 0; length clamps
    for (int i = 0; i < DEPTH - 1; i++) writeWord(i, 16'h0400 + 16'(i));
    writeWord(DEPTH - 1, 16'h2400);
    applyStimulus(32, 1, -1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(40, 0, -1, 1'b0, 1'b0, 16'h0000);

    // Random programs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        word = 16'($urandom);
        if ($urandom_range(0, 3) == 0) word[15:13] = 3'b001;
        writeWord(i, word);
      end
      applyStimulus(int'($urandom_range(0, 40)), 0, -1, 1'b0, 1'b0, 16'h0000);
    end

    // Reset in the middle of WAIT
    @(negedge clock);
    start = 1'b1;
    prog_len = 6'd3;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    checkOutput("mr_busy", 32'(busy), 32'(1));
    #1 resetn = 1'b0;
    #1;
    checkOutput("mr_run", 32'(run), 32'(0));
    checkOutput("mr_din", 32'(din), 32'(0));
    checkOutput("mr_busy_low", 32'(busy), 32'(0));
    checkOutput("mr_error", 32'(error), 32'(0));
    checkOutput("mr_finished", 32'(finished), 32'(0));
    checkOutput("mr_count", 32'(instr_count), 32'(0));
    checkOutput("mr_last", 32'(last_dout), 32'(0));
    model_count = 0;
    model_last = '0;
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(5, 0, -1, 1'b0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
